soc_boot_ctrl: RTL and testbench

SOC_BOOT_CTRL -- requirements
Module: soc_boot_ctrl

---
 rtl/croc_pkg.sv | 22 ++
 rtl/croc_sync.sv | 29 ++
 rtl/soc_boot_rst_chan.sv | 50 +++++
 rtl/soc_boot_ctrl.sv | 158 +++++++++++++++
 tb/tb_soc_boot_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/croc_pkg.sv
// Purpose: shared types and default constants for the SoC boot controller.
// Contents: boot_state_e FSM encoding, default parameter values, and an
//           index-width helper that never returns zero.
package croc_pkg;

  typedef enum logic [1:0] {
    BOOT_RESET      = 2'd0,
    BOOT_RELEASE    = 2'd1,
    BOOT_WAIT_FETCH = 2'd2,
    BOOT_RUN        = 2'd3
  } boot_state_e;

  localparam int unsigned DefNumDomains   = 2;
  localparam int unsigned DefSyncStages   = 2;
  localparam int unsigned DefReleaseDelay = 16;

  // Width of an index over n items; at least one bit so a single domain still has a legal index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/croc_sync.sv
// Purpose: multi-flop synchroniser for a single asynchronous level input.
// Ports:
//   i_clk  - destination clock
//   i_rst  - synchronous reset, active high; clears the whole chain
//   i_d    - asynchronous input
//   o_q    - synchronised output (last flop of the chain)
module croc_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [Stages-1:0] r_q;

  // Shift chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[Stages-2:0], i_d};
    end
  end

  assign o_q = r_q[Stages-1];

endmodule

// File: rtl/soc_boot_rst_chan.sv
// Purpose: per-domain software reset pulse generator.
// Ports:
//   i_clk        - system clock
//   i_rst        - synchronous reset, active high
//   i_en         - requests are accepted only while high
//   i_req        - one-cycle software reset request
//   o_held       - registered: domain is currently held in software reset
//   o_held_nxt_c - combinational: value o_held takes on the next edge
module soc_boot_rst_chan #(
  parameter int unsigned ReleaseDelay = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req,
  output logic o_held,
  output logic o_held_nxt_c
);

  localparam int unsigned CntW = $clog2(ReleaseDelay + 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            r_held;

  // A new request reloads the counter, so a repeat request stretches the pulse.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_en && i_req) begin
      w_cnt_nxt = CntW'(ReleaseDelay);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CntW'(1);
    end
  end

  assign o_held_nxt_c = (w_cnt_nxt != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_held <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_held <= o_held_nxt_c;
    end
  end

  assign o_held = r_held;

endmodule

// File: rtl/soc_boot_ctrl.sv
// Purpose: SoC boot controller. Releases domain resets one at a time, waits
//          for a synchronised fetch enable, then runs with per-domain
//          software reset pulses.
// Ports:
//   clk_i         - system clock
//   rst_i         - synchronous reset, active high
//   testmode_i    - DFT bypass: domain resets follow rst_i combinationally
//   fetch_en_i    - asynchronous fetch-enable pin
//   sw_rst_req_i  - per-domain software reset request (one-cycle pulse)
//   domain_busy_i - per-domain busy flags
//   domain_rst_no - per-domain reset, active low
//   fetch_en_o    - fetch enable to the core domain
//   boot_done_o   - high once every domain has been released
//   status_o      - registered OR of domain_busy_i
module soc_boot_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned NumDomains   = DefNumDomains,
  parameter int unsigned SyncStages   = DefSyncStages,
  parameter int unsigned ReleaseDelay = DefReleaseDelay
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  testmode_i,
  input  logic                  fetch_en_i,
  input  logic [NumDomains-1:0] sw_rst_req_i,
  input  logic [NumDomains-1:0] domain_busy_i,
  output logic [NumDomains-1:0] domain_rst_no,
  output logic                  fetch_en_o,
  output logic                  boot_done_o,
  output logic                  status_o
);

  localparam int unsigned CntW = $clog2(ReleaseDelay + 1);
  localparam int unsigned IdxW = idx_width(NumDomains);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumDomains - 1);

  boot_state_e           r_state;
  boot_state_e           w_state_nxt;
  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       w_cnt_nxt;
  logic [IdxW-1:0]       r_idx;
  logic [IdxW-1:0]       w_idx_nxt;
  logic [NumDomains-1:0] r_rel;
  logic [NumDomains-1:0] w_rel_nxt;
  logic                  r_fetch_en;
  logic                  w_fetch_en_nxt;
  logic                  r_boot_done;
  logic                  w_boot_done_nxt;
  logic                  r_status;
  logic                  w_fetch_sync;
  logic                  w_tc;
  logic                  w_run;
  logic [NumDomains-1:0] w_held;
  logic [NumDomains-1:0] w_held_nxt;

  croc_sync #(
    .Stages(SyncStages)
  ) u_fetch_sync (
    .i_clk(clk_i),
    .i_rst(rst_i),
    .i_d  (fetch_en_i),
    .o_q  (w_fetch_sync)
  );

  assign w_run = (r_state == BOOT_RUN);

  // Software reset channels only accept requests once the SoC is running.
  for (genvar k = 0; k < NumDomains; k++) begin : g_chan
    soc_boot_rst_chan #(
      .ReleaseDelay(ReleaseDelay)
    ) u_chan (
      .i_clk       (clk_i),
      .i_rst       (rst_i),
      .i_en        (w_run),
      .i_req       (sw_rst_req_i[k]),
      .o_held      (w_held[k]),
      .o_held_nxt_c(w_held_nxt[k])
    );
  end

  assign w_tc = (r_cnt == CntW'(1));

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= BOOT_RESET;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rel       <= '0;
      r_fetch_en  <= 1'b0;
      r_boot_done <= 1'b0;
      r_status    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_rel       <= w_rel_nxt;
      r_fetch_en  <= w_fetch_en_nxt;
      r_boot_done <= w_boot_done_nxt;
      r_status    <= |domain_busy_i;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT_RESET:      w_state_nxt = BOOT_RELEASE;
      BOOT_RELEASE:    if (w_tc && (r_idx == LastIdx)) w_state_nxt = BOOT_WAIT_FETCH;
      BOOT_WAIT_FETCH: if (w_fetch_sync) w_state_nxt = BOOT_RUN;
      BOOT_RUN:        w_state_nxt = BOOT_RUN;
      default:         w_state_nxt = BOOT_RESET;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_rel_nxt       = r_rel;
    w_boot_done_nxt = r_boot_done;
    w_fetch_en_nxt  = 1'b0;
    case (r_state)
      BOOT_RESET: begin
        w_cnt_nxt = CntW'(ReleaseDelay);
        w_idx_nxt = '0;
      end
      BOOT_RELEASE: begin
        if (w_tc) begin
          for (int k = 0; k < NumDomains; k++) begin
            if (r_idx == IdxW'(k)) w_rel_nxt[k] = 1'b1;
          end
          // Index stops at the last domain instead of wrapping.
          if (r_idx == LastIdx) begin
            w_cnt_nxt       = '0;
            w_boot_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IdxW'(1);
            w_cnt_nxt = CntW'(ReleaseDelay);
          end
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      BOOT_WAIT_FETCH: w_fetch_en_nxt = w_fetch_sync && !(|w_held_nxt);
      BOOT_RUN:        w_fetch_en_nxt = w_fetch_sync && !(|w_held_nxt);
      default: ;
    endcase
  end

  // Test mode bypasses sequencing so scan can control domain resets from rst_i.
  assign domain_rst_no = testmode_i ? {NumDomains{~rst_i}} : (r_rel & ~w_held);
  assign fetch_en_o    = r_fetch_en;
  assign boot_done_o   = r_boot_done;
  assign status_o      = r_status;

endmodule

// File: tb/tb_soc_boot_ctrl.sv
module tb_soc_boot_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       testmode_i;
  logic       fetch_en_i;
  logic [1:0] sw_rst_req_i;
  logic [1:0] domain_busy_i;
  logic [1:0] domain_rst_no;
  logic       fetch_en_o;
  logic       boot_done_o;
  logic       status_o;

  int n_checks = 0;
  int n_errors = 0;

  soc_boot_ctrl #(
    .NumDomains  (2),
    .SyncStages  (2),
    .ReleaseDelay(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .testmode_i   (testmode_i),
    .fetch_en_i   (fetch_en_i),
    .sw_rst_req_i (sw_rst_req_i),
    .domain_busy_i(domain_busy_i),
    .domain_rst_no(domain_rst_no),
    .fetch_en_o   (fetch_en_o),
    .boot_done_o  (boot_done_o),
    .status_o     (status_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases rst_i; the next edge is cycle 0. Checks staged release through cycle 10.
  // A request pulse during release must be ignored; busy is sampled into status once.
  task automatic release_check(input string name);
    rst_i         = 1'b0;
    fetch_en_i    = 1'b1;
    domain_busy_i = 2'b10;
    for (int c = 0; c <= 10; c++) begin
      tick();
      chk($sformatf("%s d0 c%0d", name, c), 32'(domain_rst_no[0]), 32'(c >= 4));
      chk($sformatf("%s d1 c%0d", name, c), 32'(domain_rst_no[1]), 32'(c >= 8));
      chk($sformatf("%s done c%0d", name, c), 32'(boot_done_o), 32'(c >= 8));
      chk($sformatf("%s fetch c%0d", name, c), 32'(fetch_en_o), 32'(c >= 9));
      chk($sformatf("%s status c%0d", name, c), 32'(status_o), 32'(c == 0));
      if (c == 0) domain_busy_i = 2'b00;
      if (c == 1) sw_rst_req_i = 2'b11;
      if (c == 2) sw_rst_req_i = 2'b00;
    end
  endtask

  initial begin
    rst_i         = 1'b1;
    testmode_i    = 1'b0;
    fetch_en_i    = 1'b1;
    sw_rst_req_i  = 2'b00;
    domain_busy_i = 2'b00;
    repeat (3) tick();

    // Reset state, including status held low while busy is asserted.
    domain_busy_i = 2'b01;
    tick();
    chk("rst dom", 32'(domain_rst_no), 32'h0);
    chk("rst fetch", 32'(fetch_en_o), 32'h0);
    chk("rst done", 32'(boot_done_o), 32'h0);
    chk("rst status", 32'(status_o), 32'h0);

    release_check("boot");

    // Software reset on domain 1 only.
    sw_rst_req_i = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) sw_rst_req_i = 2'b00;
      chk($sformatf("sw1 d1 +%0d", i), 32'(domain_rst_no[1]), 32'(i > 4));
      chk($sformatf("sw1 d0 +%0d", i), 32'(domain_rst_no[0]), 32'h1);
      chk($sformatf("sw1 fetch +%0d", i), 32'(fetch_en_o), 32'(i > 4));
    end

    // Repeated request on domain 0 extends the pulse.
    sw_rst_req_i = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) sw_rst_req_i = 2'b00;
      if (i == 2) sw_rst_req_i = 2'b01;
      if (i == 3) sw_rst_req_i = 2'b00;
      chk($sformatf("ext d0 +%0d", i), 32'(domain_rst_no[0]), 32'(i > 6));
      chk($sformatf("ext d1 +%0d", i), 32'(domain_rst_no[1]), 32'h1);
      chk($sformatf("ext fetch +%0d", i), 32'(fetch_en_o), 32'(i > 6));
    end

    // Simultaneous requests on both domains.
    sw_rst_req_i = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) sw_rst_req_i = 2'b00;
      chk($sformatf("both dom +%0d", i), 32'(domain_rst_no), (i > 4) ? 32'h3 : 32'h0);
    end

    // Reset asserted mid-release, then a full restart.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int c = 0; c <= 6; c++) tick();
    chk("mid d0 c6", 32'(domain_rst_no), 32'h1);
    rst_i         = 1'b1;
    domain_busy_i = 2'b11;
    tick();
    chk("mid dom c7", 32'(domain_rst_no), 32'h0);
    chk("mid fetch c7", 32'(fetch_en_o), 32'h0);
    chk("mid done c7", 32'(boot_done_o), 32'h0);
    chk("mid status c7", 32'(status_o), 32'h0);
    release_check("rerun");

    // Late fetch enable: FSM waits, fetch rises SyncStages+1 cycles later.
    rst_i      = 1'b1;
    fetch_en_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      tick();
      chk($sformatf("late done c%0d", c), 32'(boot_done_o), 32'(c >= 8));
      chk($sformatf("late fetch c%0d", c), 32'(fetch_en_o), 32'(c >= 23));
      if (c == 20) fetch_en_i = 1'b1;
    end

    // Test mode: domain resets follow ~rst_i in the same cycle.
    testmode_i = 1'b1;
    rst_i      = 1'b1;
    #1;
    chk("tm rst1", 32'(domain_rst_no), 32'h0);
    rst_i = 1'b0;
    #1;
    chk("tm rst0", 32'(domain_rst_no), 32'h3);
    rst_i = 1'b1;
    #1;
    chk("tm rst1b", 32'(domain_rst_no), 32'h0);
    tick();
    chk("tm rst1 edge", 32'(domain_rst_no), 32'h0);
    chk("tm done", 32'(boot_done_o), 32'h0);
    rst_i = 1'b0;
    #1;
    chk("tm rst0b", 32'(domain_rst_no), 32'h3);
    testmode_i = 1'b0;
    #1;
    chk("tm off", 32'(domain_rst_no), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
